// File: rtl/forth_token_sequencer.sv
// Forth compiler front end: splits a UART character stream into
// whitespace-delimited words, converts decimal literals into PUSH results and
// hands every other word to an external word-to-opcode translator whose answer
// is returned to the execution core over a valid/ready handshake.
module forth_token_sequencer #(
   parameter  int WIDTH      = 32,
   parameter  int DATA       = 32,
   parameter  int OPCODE     = 16,
   localparam int WIDTH_BITS = $clog2(WIDTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rx_valid,
   input  logic [7:0]            i_rx_data,
   output logic                  o_rx_ready,
   output logic                  o_word_en,
   output logic [8*WIDTH-1:0]    o_word,
   output logic [WIDTH_BITS-1:0] o_len,
   input  logic [OPCODE-1:0]     i_tr_opcode,
   input  logic [DATA-1:0]       i_tr_data,
   input  logic                  i_tr_err,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [OPCODE-1:0]     o_opcode,
   output logic [DATA-1:0]       o_data,
   output logic                  o_err
);

   localparam logic [1:0] ST_COLLECT  = 2'd0;
   localparam logic [1:0] ST_DISPATCH = 2'd1;
   localparam logic [1:0] ST_WAIT     = 2'd2;
   localparam logic [1:0] ST_EMIT     = 2'd3;

   localparam logic [OPCODE-1:0]     OP_NONE = '0;
   localparam logic [OPCODE-1:0]     OP_PUSH = OPCODE'(1);
   localparam logic [WIDTH_BITS-1:0] LEN_MAX = WIDTH_BITS'(WIDTH);
   localparam logic [WIDTH_BITS-1:0] LEN_ONE = WIDTH_BITS'(1);

   logic [1:0]            state_q,   state_d;
   logic [WIDTH_BITS-1:0] len_q,     len_d;
   logic [8*WIDTH-1:0]    buf_q,     buf_d;
   logic [DATA-1:0]       acc_q,     acc_d;
   logic                  numeric_q, numeric_d;
   logic                  neg_q,     neg_d;
   logic                  ovf_q,     ovf_d;
   logic [OPCODE-1:0]     opcode_q,  opcode_d;
   logic [DATA-1:0]       data_q,    data_d;
   logic                  err_q,     err_d;

   logic rx_fire;
   logic rx_delim;
   logic rx_digit;
   logic lone_minus;

   function automatic logic is_delim(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
   endfunction

   // Two's-complement negation of the accumulated magnitude when '-' led the word.
   function automatic logic [DATA-1:0] apply_sign(input logic [DATA-1:0] mag,
                                                  input logic            neg);
      logic signed [DATA-1:0] s;
      s = mag;
      if (neg) s = -s;
      return s;
   endfunction

   // acc*10 + digit with natural wrap modulo 2^DATA.
   function automatic logic [DATA-1:0] acc_step(input logic [DATA-1:0] acc,
                                                input logic [3:0]      digit);
      return (acc << 3) + (acc << 1) + {{(DATA-4){1'b0}}, digit};
   endfunction

   assign rx_fire    = i_rx_valid && (state_q == ST_COLLECT);
   assign rx_delim   = is_delim(i_rx_data);
   assign rx_digit   = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
   // A word consisting of just "-" never saw a digit, so it is not a literal.
   assign lone_minus = neg_q && (len_q == LEN_ONE);

   // Next-state logic: word collection, literal tracking and result capture.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      buf_d     = buf_q;
      acc_d     = acc_q;
      numeric_d = numeric_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      opcode_d  = opcode_q;
      data_d    = data_q;
      err_d     = err_q;

      case (state_q)
         ST_COLLECT: begin
            if (rx_fire) begin
               if (rx_delim) begin
                  if (len_q != '0) begin
                     if (ovf_q) begin
                        opcode_d = OP_NONE;
                        data_d   = '0;
                        err_d    = 1'b1;
                        state_d  = ST_EMIT;
                     end else if (numeric_q && !lone_minus) begin
                        opcode_d = OP_PUSH;
                        data_d   = apply_sign(acc_q, neg_q);
                        err_d    = 1'b0;
                        state_d  = ST_EMIT;
                     end else begin
                        state_d  = ST_DISPATCH;
                     end
                  end
               end else if (len_q < LEN_MAX) begin
                  buf_d[8*int'(len_q) +: 8] = i_rx_data;
                  len_d = len_q + LEN_ONE;
                  if (rx_digit) begin
                     acc_d = acc_step(acc_q, i_rx_data[3:0]);
                  end else if ((i_rx_data == 8'h2D) && (len_q == '0)) begin
                     neg_d = 1'b1;
                  end else begin
                     numeric_d = 1'b0;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         ST_DISPATCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Translator output is registered one cycle after o_word_en.
            opcode_d = i_tr_opcode;
            data_d   = i_tr_data;
            err_d    = i_tr_err;
            state_d  = ST_EMIT;
         end
         default: begin
            if (i_ready) begin
               len_d     = '0;
               buf_d     = '0;
               acc_d     = '0;
               numeric_d = 1'b1;
               neg_d     = 1'b0;
               ovf_d     = 1'b0;
               state_d   = ST_COLLECT;
            end
         end
      endcase
   end

   // State and datapath registers; reset drops any partial word or pending result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_COLLECT;
         len_q     <= '0;
         buf_q     <= '0;
         acc_q     <= '0;
         numeric_q <= 1'b1;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         opcode_q  <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         buf_q     <= buf_d;
         acc_q     <= acc_d;
         numeric_q <= numeric_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         opcode_q  <= opcode_d;
         data_q    <= data_d;
         err_q     <= err_d;
      end
   end

   assign o_rx_ready = (state_q == ST_COLLECT);
   assign o_word_en  = (state_q == ST_DISPATCH);
   assign o_valid    = (state_q == ST_EMIT);
   assign o_word     = buf_q;
   assign o_len      = len_q;
   assign o_opcode   = opcode_q;
   assign o_data     = data_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_forth_token_sequencer.sv
// Directed bench for forth_token_sequencer with a registered translator model.
module tb_forth_token_sequencer;

   localparam int WIDTH      = 32;
   localparam int DATA       = 32;
   localparam int OPCODE     = 16;
   localparam int WIDTH_BITS = $clog2(WIDTH) + 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  rx_valid = 1'b0;
   logic [7:0]            rx_data = 8'h00;
   logic                  rx_ready;
   logic                  word_en;
   logic [8*WIDTH-1:0]    word;
   logic [WIDTH_BITS-1:0] len;
   logic [OPCODE-1:0]     tr_opcode = '0;
   logic [DATA-1:0]       tr_data = '0;
   logic                  tr_err = 1'b0;
   logic                  valid;
   logic                  ready = 1'b1;
   logic [OPCODE-1:0]     opcode;
   logic [DATA-1:0]       data;
   logic                  err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int wen_count = 0;
   int wen_cyc = 0;
   logic [WIDTH_BITS-1:0] wen_len = '0;
   logic [8*WIDTH-1:0]    wen_word = '0;

   typedef struct {
      logic [OPCODE-1:0] op;
      logic [DATA-1:0]   data;
      logic              err;
      int                cyc;
   } res_t;
   res_t res_q[$];

   forth_token_sequencer #(.WIDTH(WIDTH), .DATA(DATA), .OPCODE(OPCODE)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
      .o_word_en(word_en), .o_word(word), .o_len(len),
      .i_tr_opcode(tr_opcode), .i_tr_data(tr_data), .i_tr_err(tr_err),
      .o_valid(valid), .i_ready(ready),
      .o_opcode(opcode), .o_data(data), .o_err(err)
   );

   always #5 clk = ~clk;

   // Cycle counter advanced on the active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Translator dictionary lookup.
   function automatic logic [OPCODE-1:0] lookup(input logic [8*WIDTH-1:0] w,
                                               input logic [WIDTH_BITS-1:0] l);
      if (l == 3 && w[23:0] == 24'h505544) return 16'd7;   // DUP
      if (l == 4 && w[31:0] == 32'h50415753) return 16'd9; // SWAP
      if (l == 1 && w[7:0] == 8'h2D) return 16'd4;         // -
      if (l == 1 && w[7:0] == 8'h2B) return 16'd3;         // +
      if (l == 1 && w[7:0] == 8'h2A) return 16'd5;         // *
      return 16'hEEEE;
   endfunction

   // Registered translator: answers one cycle after o_word_en.
   always @(posedge clk) begin
      if (word_en) begin
         tr_opcode <= lookup(word, len);
         tr_data   <= 32'hA000_0000 | {16'h0, lookup(word, len)};
         tr_err    <= (lookup(word, len) == 16'hEEEE);
      end
   end

   // Monitor on the inactive edge: records handshakes and translator requests.
   always @(negedge clk) begin
      if (valid && ready) res_q.push_back('{op: opcode, data: data, err: err, cyc: cyc});
      if (word_en) begin
         wen_count <= wen_count + 1;
         wen_cyc   <= cyc;
         wen_len   <= len;
         wen_word  <= word;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_char(input logic [7:0] c);
      int n;
      n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = c;
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_char_timeout: char %h not accepted in %0d cycles, required acceptance", c, n);
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
      checks++; if (word_en !== 1'b0) begin errors++; $display("FAIL reset_word_en: got %b want 0", word_en); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (opcode !== '0 || data !== '0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_result: got op=%h data=%h err=%b want 0/0/0", opcode, data, err);
      end
      checks++; if (len !== '0 || word !== '0) begin
         errors++; $display("FAIL reset_word: got len=%0d word=%h want 0/0", len, word);
      end
      @(negedge clk) rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_literal(input string s, input logic [DATA-1:0] exp, input string nm);
      int w0;
      res_q.delete();
      w0 = wen_count;
      send_str(s);
      wait_cycles(6);
      checks++; if (res_q.size() != 1) begin
         errors++; $display("FAIL %s_count: got %0d results want 1", nm, res_q.size());
      end else begin
         checks++; if (res_q[0].op !== 16'd1 || res_q[0].data !== exp || res_q[0].err !== 1'b0) begin
            errors++; $display("FAIL %s_result: got op=%h data=%h err=%b want 0001/%h/0", nm,
                               res_q[0].op, res_q[0].data, res_q[0].err, exp);
         end
         checks++; if (res_q[0].cyc - acc_cyc != 1) begin
            errors++; $display("FAIL %s_latency: got %0d want 1", nm, res_q[0].cyc - acc_cyc);
         end
      end
      checks++; if (wen_count != w0) begin
         errors++; $display("FAIL %s_no_word_en: got %0d pulses want 0", nm, wen_count - w0);
      end
   endtask

   task automatic test_translated(input string s, input logic [WIDTH_BITS-1:0] exp_len,
                                  input logic [31:0] exp_bytes, input logic [OPCODE-1:0] exp_op,
                                  input string nm);
      int w0;
      logic [31:0] mask;
      res_q.delete();
      w0 = wen_count;
      send_str(s);
      wait_cycles(6);
      mask = (exp_len >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * exp_len)) - 1);
      checks++; if (wen_count - w0 != 1) begin
         errors++; $display("FAIL %s_word_en_pulses: got %0d want 1", nm, wen_count - w0);
      end
      checks++; if (wen_len !== exp_len || (wen_word[31:0] & mask) !== exp_bytes) begin
         errors++; $display("FAIL %s_word: got len=%0d bytes=%h want len=%0d bytes=%h", nm,
                            wen_len, wen_word[31:0] & mask, exp_len, exp_bytes);
      end
      checks++; if (res_q.size() != 1) begin
         errors++; $display("FAIL %s_count: got %0d results want 1", nm, res_q.size());
      end else begin
         checks++; if (res_q[0].op !== exp_op || res_q[0].err !== 1'b0 ||
                       res_q[0].data !== (32'hA000_0000 | {16'h0, exp_op})) begin
            errors++; $display("FAIL %s_result: got op=%h data=%h err=%b want op=%h err=0", nm,
                               res_q[0].op, res_q[0].data, res_q[0].err, exp_op);
         end
         checks++; if (wen_cyc - acc_cyc != 1 || res_q[0].cyc - acc_cyc != 3) begin
            errors++; $display("FAIL %s_latency: got word_en+%0d valid+%0d want +1/+3", nm,
                               wen_cyc - acc_cyc, res_q[0].cyc - acc_cyc);
         end
      end
   endtask

   task automatic test_back_to_back;
      int w0;
      logic [OPCODE-1:0] held_op;
      res_q.delete();
      w0 = wen_count;
      ready = 1'b0;
      fork
         send_str("   + \t\t* ");
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            checks++; if (!valid) begin
               errors++; $display("FAIL bp_first_valid: got no o_valid within %0d cycles", n);
            end
            held_op = opcode;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               checks++; if (valid !== 1'b1 || rx_ready !== 1'b0 || opcode !== held_op || opcode !== 16'd3) begin
                  errors++; $display("FAIL bp_hold_%0d: got valid=%b rx_ready=%b op=%h want 1/0/0003",
                                     i, valid, rx_ready, opcode);
               end
            end
            @(posedge clk);
            #1 ready = 1'b1;
         end
      join
      wait_cycles(8);
      checks++; if (res_q.size() != 2) begin
         errors++; $display("FAIL bp_count: got %0d results want 2", res_q.size());
      end else begin
         checks++; if (res_q[0].op !== 16'd3 || res_q[1].op !== 16'd5) begin
            errors++; $display("FAIL bp_order: got %h,%h want 0003,0005", res_q[0].op, res_q[1].op);
         end
      end
      checks++; if (wen_count - w0 != 2) begin
         errors++; $display("FAIL bp_word_en_pulses: got %0d want 2", wen_count - w0);
      end
   endtask

   task automatic test_overflow;
      int w0;
      res_q.delete();
      w0 = wen_count;
      for (int i = 0; i < 33; i++) send_char(8'h41);
      send_char(8'h20);
      wait_cycles(6);
      checks++; if (res_q.size() != 1) begin
         errors++; $display("FAIL ovf_count: got %0d results want 1", res_q.size());
      end else begin
         checks++; if (res_q[0].op !== '0 || res_q[0].data !== '0 || res_q[0].err !== 1'b1) begin
            errors++; $display("FAIL ovf_result: got op=%h data=%h err=%b want 0/0/1",
                               res_q[0].op, res_q[0].data, res_q[0].err);
         end
         checks++; if (res_q[0].cyc - acc_cyc != 1) begin
            errors++; $display("FAIL ovf_latency: got %0d want 1", res_q[0].cyc - acc_cyc);
         end
      end
      checks++; if (wen_count != w0) begin
         errors++; $display("FAIL ovf_no_word_en: got %0d pulses want 0", wen_count - w0);
      end
   endtask

   task automatic test_mid_word_reset;
      send_str("SWA");
      @(negedge clk) rst_n = 1'b0;
      #1;
      checks++; if (len !== '0 || word !== '0 || valid !== 1'b0 || rx_ready !== 1'b1 || word_en !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got len=%0d word=%h valid=%b rx_ready=%b word_en=%b want 0/0/0/1/0",
                            len, word, valid, rx_ready, word_en);
      end
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(1);
      test_translated("SWAP ", 4, 32'h50415753, 16'd9, "swap");
   endtask

   initial begin
      test_reset();
      test_literal("12 ", 32'd12, "lit12");
      test_literal("-7\n", 32'hFFFF_FFF9, "litneg7");
      test_translated("DUP ", 3, 32'h00505544, 16'd7, "dup");
      test_translated("- ", 1, 32'h0000002D, 16'd4, "minus");
      test_back_to_back();
      test_overflow();
      test_mid_word_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
